// File: rtl/decode_issue_buffer_pkg.sv
// decode_issue_buffer_pkg
// Shared constants for the decode-to-rename issue buffer.
//   ISSUE_WIDTH_MAX : widest decode/rename group in the core
//   DATA_LEN        : instruction word width
//   IBUF_*          : default geometry of the issue buffer
package decode_issue_buffer_pkg;

  localparam int ISSUE_WIDTH_MAX = 4;
  localparam int DATA_LEN        = 32;

  localparam int IBUF_DEPTH      = 16;
  localparam int IBUF_ENQ_WIDTH  = ISSUE_WIDTH_MAX;
  localparam int IBUF_DEQ_WIDTH  = ISSUE_WIDTH_MAX;

endpackage

// File: rtl/decode_issue_buffer_enq_compact.sv
// decode_issue_buffer_enq_compact
// Purely combinational. Squeezes a sparse decode group into a dense list:
// valid slots are packed in ascending slot order starting at output slot 0,
// and the number of valid slots is reported.
// Ports:
//   enq_val      in  WIDTH            per-slot valid (may have holes)
//   enq_instr    in  WIDTH*INSTR_LEN  per-slot instruction words
//   packed_instr out WIDTH*INSTR_LEN  compacted words; unused slots are zero
//   packed_count out clog2(WIDTH+1)   popcount(enq_val)
module decode_issue_buffer_enq_compact #(
  parameter int WIDTH     = 4,
  parameter int INSTR_LEN = 32,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]           enq_val,
  input  logic [WIDTH*INSTR_LEN-1:0] enq_instr,
  output logic [WIDTH*INSTR_LEN-1:0] packed_instr,
  output logic [CNT_W-1:0]           packed_count
);

  // slot_pos[i] = number of valid slots below slot i, i.e. where slot i lands
  logic [CNT_W-1:0] slot_pos [WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pos
      logic [CNT_W-1:0] pos;
      always_comb begin
        pos = '0;
        for (int k = 0; k < gi; k++) begin
          pos = pos + CNT_W'(enq_val[k]);
        end
      end
      assign slot_pos[gi] = pos;
    end

    // Each output slot ORs in the single input slot whose landing position
    // matches it; at most one input can match.
    for (gi = 0; gi < WIDTH; gi++) begin : g_out
      logic [INSTR_LEN-1:0] word;
      always_comb begin
        word = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (enq_val[i] && (slot_pos[i] == CNT_W'(gi))) begin
            word = word | enq_instr[i*INSTR_LEN +: INSTR_LEN];
          end
        end
      end
      assign packed_instr[gi*INSTR_LEN +: INSTR_LEN] = word;
    end
  endgenerate

  always_comb begin
    packed_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      packed_count = packed_count + CNT_W'(enq_val[i]);
    end
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer
// Circular instruction buffer between decode and rename. Decode writes up to
// ENQ_WIDTH (possibly sparse) instructions per cycle; rename is offered up to
// DEQ_WIDTH oldest instructions per cycle and consumes every lane it is shown.
// Ports:
//   clk        in   core clock
//   rst        in   synchronous active-high reset (pointers and count only)
//   flush      in   discard all buffered entries
//   enq_val    in   ENQ_WIDTH per-slot valid from decode
//   enq_instr  in   ENQ_WIDTH x INSTR_LEN instruction words
//   enq_rdy    out  room for a whole ENQ_WIDTH group
//   stall      in   rename cannot accept this cycle
//   deq_val    out  DEQ_WIDTH per-lane valid, contiguous from lane 0
//   deq_instr  out  DEQ_WIDTH x INSTR_LEN, oldest in lane 0
//   occupancy  out  current entry count
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int ENQ_WIDTH = IBUF_ENQ_WIDTH,
  parameter int DEQ_WIDTH = IBUF_DEQ_WIDTH,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int INSTR_LEN = DATA_LEN,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ENQ_WIDTH-1:0]           enq_val,
  input  logic [ENQ_WIDTH*INSTR_LEN-1:0] enq_instr,
  output logic                           enq_rdy,
  input  logic                           stall,
  output logic [DEQ_WIDTH-1:0]           deq_val,
  output logic [DEQ_WIDTH*INSTR_LEN-1:0] deq_instr,
  output logic [CNT_W-1:0]               occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ECW   = $clog2(ENQ_WIDTH + 1);

  // Entry storage; never reset, only the pointers and count are.
  logic [INSTR_LEN-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [ENQ_WIDTH*INSTR_LEN-1:0] packed_instr;
  logic [ECW-1:0]                 packed_count;
  logic                           enq_fire;
  logic [CNT_W-1:0]               enq_count;
  logic [CNT_W-1:0]               deq_count;
  logic                           deq_active;

  decode_issue_buffer_enq_compact #(
    .WIDTH    (ENQ_WIDTH),
    .INSTR_LEN(INSTR_LEN)
  ) enq_compact (
    .enq_val     (enq_val),
    .enq_instr   (enq_instr),
    .packed_instr(packed_instr),
    .packed_count(packed_count)
  );

  // Readiness looks only at the registered count: a full group must fit even
  // if rename takes nothing this cycle.
  assign enq_rdy   = (DEPTH - int'(count_reg)) >= ENQ_WIDTH;
  assign enq_fire  = enq_rdy && (|enq_val) && !flush;
  assign enq_count = enq_fire ? CNT_W'(packed_count) : '0;
  assign occupancy = count_reg;

  // Lanes are presented straight from registered state; rename takes all of
  // them, so the valid lanes are always the low min(count, DEQ_WIDTH).
  assign deq_active = !rst && !stall && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
      assign deq_val[gi] = deq_active && (int'(count_reg) > gi);
      assign deq_instr[gi*INSTR_LEN +: INSTR_LEN] = mem[head_reg + PTR_W'(gi)];
    end
  endgenerate

  always_comb begin
    deq_count = '0;
    if (deq_active) begin
      deq_count = (int'(count_reg) > DEQ_WIDTH) ? CNT_W'(DEQ_WIDTH) : count_reg;
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign head_next  = head_reg + PTR_W'(deq_count);
  assign tail_next  = tail_reg + PTR_W'(enq_count);
  assign count_next = count_reg + enq_count - deq_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (int'(packed_count) > k) begin
          mem[tail_reg + PTR_W'(k)] <= packed_instr[k*INSTR_LEN +: INSTR_LEN];
        end
      end
    end
  end

  // Structural invariants of the ring.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    enq_fire |-> (int'(count_reg) + int'(packed_count) <= DEPTH));
  a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
    (tail_reg - head_reg) == PTR_W'(count_reg));
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    int'(count_reg) <= DEPTH);

endmodule
